// File: rtl/mc_control_if.sv
// Control bundle between the multicycle main control FSM and the MIPS datapath.
// The master side is the control FSM. The slave side is the datapath, which supplies the opcode.
interface mc_control_if;
    logic [5:0] op;
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       irwrite;
    logic [1:0] pcsource;
    logic       aluop1;
    logic       aluop0;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       regwrite;
    logic       regdst;
    logic [3:0] state;

    modport master (
        input  op,
        output pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite,
               pcsource, aluop1, aluop0, alusrca, alusrcb, regwrite, regdst, state
    );

    modport slave (
        output op,
        input  pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite,
               pcsource, aluop1, aluop0, alusrca, alusrcb, regwrite, regdst, state
    );
endinterface

// File: rtl/mc_control.sv
// Multicycle MIPS main control: a Moore FSM sequencing fetch/decode/execute/memory/writeback.
// Define MC_CONTROL_ADDI_EN to add the addi path (states ADDIEX/ADDIWB).
module mc_control (
    input  logic clk,
    input  logic reset,
    mc_control_if.master bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RCOMP  = 4'd7,
        BEQ    = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CONTROL_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BEQ;
                    OP_J:         state_d = JUMP;
`ifdef MC_CONTROL_ADDI_EN
                    OP_ADDI:      state_d = ADDIEX;
`endif
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: state_d = (bus.op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  state_d = MEMWB;
            EXEC:   state_d = RCOMP;
`ifdef MC_CONTROL_ADDI_EN
            ADDIEX: state_d = ADDIWB;
`endif
            default: state_d = FETCH;
        endcase
    end

    // Outputs depend on the registered state only; unused encodings leave everything low.
    always_comb begin
        bus.pcwrite     = 1'b0;
        bus.pcwritecond = 1'b0;
        bus.iord        = 1'b0;
        bus.memread     = 1'b0;
        bus.memwrite    = 1'b0;
        bus.memtoreg    = 1'b0;
        bus.irwrite     = 1'b0;
        bus.pcsource    = 2'b00;
        bus.aluop1      = 1'b0;
        bus.aluop0      = 1'b0;
        bus.alusrca     = 1'b0;
        bus.alusrcb     = 2'b00;
        bus.regwrite    = 1'b0;
        bus.regdst      = 1'b0;
        case (state_q)
            FETCH: begin
                bus.memread = 1'b1;
                bus.irwrite = 1'b1;
                bus.alusrcb = 2'b01;
                bus.pcwrite = 1'b1;
            end
            DECODE: bus.alusrcb = 2'b11;
            MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            MEMRD: begin
                bus.memread = 1'b1;
                bus.iord    = 1'b1;
            end
            MEMWB: begin
                bus.regwrite = 1'b1;
                bus.memtoreg = 1'b1;
            end
            MEMWR: begin
                bus.memwrite = 1'b1;
                bus.iord     = 1'b1;
            end
            EXEC: begin
                bus.alusrca = 1'b1;
                bus.aluop1  = 1'b1;
            end
            RCOMP: begin
                bus.regwrite = 1'b1;
                bus.regdst   = 1'b1;
            end
            BEQ: begin
                bus.alusrca     = 1'b1;
                bus.aluop0      = 1'b1;
                bus.pcwritecond = 1'b1;
                bus.pcsource    = 2'b01;
            end
            JUMP: begin
                bus.pcwrite  = 1'b1;
                bus.pcsource = 2'b10;
            end
`ifdef MC_CONTROL_ADDI_EN
            ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            ADDIWB: bus.regwrite = 1'b1;
`endif
            default: ;
        endcase
    end

    assign bus.state = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: instruction-path model plus per-state output ROM, checked every cycle.
// Honours MC_CONTROL_ADDI_EN the same way the design does.
module tb_mc_control;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mc_control_if bus();

    mc_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

`ifdef MC_CONTROL_ADDI_EN
    localparam int ADDI_CYCLES = 4;
`else
    localparam int ADDI_CYCLES = 2;
`endif

    int vectors     = 0;
    int miscompares = 0;

    int   expState   = 0;
    int   expPath[$];
    logic modelValid = 1'b0;

    int lastRegw;
    int lastMemw;

    // Expected output word per state, fields {pcwrite, pcwritecond, iord, memread, memwrite,
    // memtoreg, irwrite, pcsource[1:0], aluop1, aluop0, alusrca, alusrcb[1:0], regwrite, regdst}.
    function automatic logic [15:0] expOut(input int s);
        case (s)
            0:  return 16'h9204;
            1:  return 16'h000C;
            2:  return 16'h0018;
            3:  return 16'h3000;
            4:  return 16'h0402;
            5:  return 16'h2800;
            6:  return 16'h0050;
            7:  return 16'h0003;
            8:  return 16'h40B0;
            9:  return 16'h8100;
`ifdef MC_CONTROL_ADDI_EN
            10: return 16'h0018;
            11: return 16'h0002;
`endif
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] packOut();
        return {bus.pcwrite, bus.pcwritecond, bus.iord, bus.memread, bus.memwrite,
                bus.memtoreg, bus.irwrite, bus.pcsource, bus.aluop1, bus.aluop0,
                bus.alusrca, bus.alusrcb, bus.regwrite, bus.regdst};
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each instruction is a list of states after FETCH, chosen by the opcode seen leaving FETCH.
    always @(posedge clk) begin
        if (reset) begin
            expState = 0;
            expPath.delete();
            modelValid = 1'b1;
        end else if (modelValid) begin
            if (expPath.size() > 0) begin
                expState = expPath.pop_front();
            end else if (expState != 0) begin
                expState = 0;
            end else begin
                expPath.push_back(1);
                case (bus.op)
                    OP_LW:  begin expPath.push_back(2); expPath.push_back(3); expPath.push_back(4); end
                    OP_SW:  begin expPath.push_back(2); expPath.push_back(5); end
                    OP_R:   begin expPath.push_back(6); expPath.push_back(7); end
                    OP_BEQ: expPath.push_back(8);
                    OP_J:   expPath.push_back(9);
`ifdef MC_CONTROL_ADDI_EN
                    OP_ADDI: begin expPath.push_back(10); expPath.push_back(11); end
`endif
                    default: ;
                endcase
                expState = expPath.pop_front();
            end
        end
    end

    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("state", {12'h000, bus.state}, 16'(expState));
            checkOutput("outputs", packOut(), expOut(expState));
        end
    end

    // Called at a falling edge while in FETCH; runs one instruction back to FETCH.
    task automatic applyStimulus(input string name, input logic [5:0] o, input int expCycles);
        int cycles;
        bit done;
        bus.op   = o;
        cycles   = 1;
        done     = 1'b0;
        lastRegw = 0;
        lastMemw = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus.state == 4'd0) begin
                done = 1'b1;
            end else begin
                cycles++;
                lastRegw += int'(bus.regwrite);
                lastMemw += int'(bus.memwrite);
            end
        end
        checkOutput({name, "_cycles"}, 16'(cycles), 16'(expCycles));
    endtask

    initial begin
        bit found;
        reset  = 1'b1;
        bus.op = OP_R;
        repeat (2) @(negedge clk);

        checkOutput("rst_state",    {12'h000, bus.state}, 16'h0000);
        checkOutput("rst_memread",  {15'h0, bus.memread},  16'h0001);
        checkOutput("rst_irwrite",  {15'h0, bus.irwrite},  16'h0001);
        checkOutput("rst_pcwrite",  {15'h0, bus.pcwrite},  16'h0001);
        checkOutput("rst_alusrcb",  {14'h0, bus.alusrcb},  16'h0001);
        checkOutput("rst_regwrite", {15'h0, bus.regwrite}, 16'h0000);
        reset = 1'b0;

        applyStimulus("rtype", OP_R, 4);
        checkOutput("rtype_regwrite_count", 16'(lastRegw), 16'd1);
        applyStimulus("lw", OP_LW, 5);
        checkOutput("lw_regwrite_count", 16'(lastRegw), 16'd1);
        applyStimulus("sw", OP_SW, 4);
        checkOutput("sw_regwrite_count", 16'(lastRegw), 16'd0);
        checkOutput("sw_memwrite_count", 16'(lastMemw), 16'd1);
        applyStimulus("beq", OP_BEQ, 3);
        applyStimulus("j", OP_J, 3);
        applyStimulus("undef", OP_BAD, 2);
        checkOutput("undef_regwrite_count", 16'(lastRegw), 16'd0);
        applyStimulus("addi", OP_ADDI, ADDI_CYCLES);

        // Abort an lw while it sits in the memory-read step.
        bus.op = OP_LW;
        found  = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (bus.state == 4'd3) found = 1'b1;
        end
        checkOutput("reach_memrd", {15'h0, found}, 16'h0001);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_state",    {12'h000, bus.state}, 16'h0000);
        checkOutput("midreset_regwrite", {15'h0, bus.regwrite}, 16'h0000);
        reset = 1'b0;

        applyStimulus("rtype_after_reset", OP_R, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle main control FSM for the MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback steps, and drives the per-cycle datapath enables and mux selects. It also drives the `aluop1`/`aluop0` pair consumed by the ALU control unit, which in turn produces the 3-bit ALU operation. It sits directly upstream of the ALU control unit and reads the opcode field from the instruction register.

## Interface
Parameters: none; state encoding is fixed below.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; state goes to FETCH on the next rising edge.
- `op`  in  6  opcode, IR[31:26].
- `pcwrite`  out  1  unconditional PC load.
- `pcwritecond`  out  1  PC load qualified by ALU zero (beq).
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `memread`  out  1  memory read strobe.
- `memwrite`  out  1  memory write strobe.
- `memtoreg`  out  1  register write data select: 1 = MDR, 0 = ALUOut.
- `irwrite`  out  1  IR load.
- `pcsource`  out  2  PC source select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- `aluop1`, `aluop0`  out  1 each  to ALU control: 00 = add, 01 = sub, 10 = funct-decoded.
- `alusrca`  out  1  ALU A select: 0 = PC, 1 = A register.
- `alusrcb`  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted immediate.
- `regwrite`  out  1  register file write.
- `regdst`  out  1  destination register select: 1 = rd, 0 = rt.
- `state`  out  4  current state, for debug and visibility.

## Operation
- Moore machine. All outputs decode from the registered state only. Any output not listed for a state is 0.
- States and their asserted outputs:
  - 0 FETCH: `memread`, `irwrite`, `alusrcb`=01, `pcwrite`, `pcsource`=00. Next: DECODE.
  - 1 DECODE: `alusrcb`=11. Next state from `op`:
    - 100011 (lw) / 101011 (sw) → MEMADR
    - 000000 (R-type) → EXEC
    - 000100 (beq) → BEQ
    - 000010 (j) → JUMP
    - any other opcode → FETCH. No write strobe is asserted in this case.
  - 2 MEMADR: `alusrca`=1, `alusrcb`=10. Next: MEMRD if lw, MEMWR if sw.
  - 3 MEMRD: `memread`, `iord`. Next: MEMWB.
  - 4 MEMWB: `regwrite`, `memtoreg`. Next: FETCH.
  - 5 MEMWR: `memwrite`, `iord`. Next: FETCH.
  - 6 EXEC: `alusrca`=1, `aluop1`=1. Next: RCOMP.
  - 7 RCOMP: `regwrite`, `regdst`. Next: FETCH.
  - 8 BEQ: `alusrca`=1, `aluop0`=1, `pcwritecond`, `pcsource`=01. Next: FETCH.
  - 9 JUMP: `pcwrite`, `pcsource`=10. Next: FETCH.
- Encodings 10–15 that are not used (see Configuration) go to FETCH on the next edge. While in one of them, all outputs are 0.
- `op` is sampled in DECODE and MEMADR. The IR holds `op` stable from DECODE until the instruction completes.

## Timing
- Reset: if `reset` = 1 at an edge, state = 0 after that edge, regardless of the current state. This includes mid-instruction; a pending write strobe is dropped.
- After reset, outputs equal the FETCH values: `memread`=1, `irwrite`=1, `pcwrite`=1, `alusrcb`=01. All other outputs are 0.
- Cycle counts, FETCH to the next FETCH: lw 5, sw 4, R-type 4, beq 3, j 3, undefined opcode 2.
- Each write strobe (`regwrite`, `memwrite`, `pcwrite`, `pcwritecond`, `irwrite`) is high for exactly one cycle per instruction step that owns it.

## Configuration
- `MC_CONTROL_ADDI_EN` defined:
  - DECODE with `op`=001000 → state 10 ADDIEX: `alusrca`=1, `alusrcb`=10, aluop=00. Next: ADDIWB.
  - 11 ADDIWB: `regwrite`; `regdst`=0; `memtoreg`=0. Next: FETCH.
  - addi takes 4 cycles.
- `MC_CONTROL_ADDI_EN` not defined: `op`=001000 is an undefined opcode (DECODE → FETCH), and states 10/11 are unreachable.

## Test plan
- Reset held 2 cycles, then released with `op`=000000 → `state` sequence 0, 1, 6, 7, 0. `aluop1`=1 only in state 6; `regwrite`=1 and `regdst`=1 only in state 7.
- `op`=100011 → states 0, 1, 2, 3, 4, 0. `iord`=1 and `memread`=1 in state 3; `regwrite`=1 and `memtoreg`=1 in state 4.
- `op`=101011 → states 0, 1, 2, 5, 0. `memwrite`=1 in state 5 only. `regwrite` is never asserted.
- `op`=000100 then `op`=000010 → states 0, 1, 8 with `pcwritecond`=1, `pcsource`=01, `aluop0`=1; then 0, 1, 9 with `pcwrite`=1, `pcsource`=10.
- `op`=111111 → states 0, 1, 0, with no write strobe in state 1. Then `op`=001000: with the macro, states 0, 1, 10, 11, 0; without the macro, states 0, 1, 0.
- `reset` asserted during state 3 of an lw → `state`=0 on the next edge. State 4 is never entered and `regwrite` stays 0.
